// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: latches a parallel pattern and shifts it out MSB-first on x,
// one bit per clock, with t high for every valid bit. The pattern is repeated
// repeat_n+1 times back-to-back. All outputs are registered.
// Optional feature macro: PARITY_EN adds one even-parity bit (state PAR) after
// every pass. When it is undefined, passes are WIDTH bits only.
module serial_pattern_tx #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             ready,
   output logic             busy,
   output logic             x,
   output logic             t,
   output logic             done
);

   localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IdxW-1:0] IdxTop = IdxW'(WIDTH - 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
   typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

   state_e state_q, state_d;

   logic [WIDTH-1:0] pat_q, pat_d;
   // Remaining extra passes; tested for zero before decrementing so it never wraps.
   logic [CNT_W-1:0] pass_q, pass_d;
   // Index of the bit currently on x.
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             x_q, x_d;
   logic             t_q, t_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;

   logic            accept;
   logic            last_bit;
   logic            more_passes;
   logic [IdxW-1:0] idx_m1;

   assign accept      = start & ~abort;
   assign last_bit    = (idx_q == '0);
   assign more_passes = (pass_q != '0);
   assign idx_m1      = idx_q - IdxW'(1);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) state_d = StShift;
         end
         StShift: begin
            if (abort) begin
               state_d = StIdle;
            end else if (last_bit) begin
`ifdef PARITY_EN
               state_d = StPar;
`else
               if (!more_passes) state_d = StIdle;
`endif
            end
         end
`ifdef PARITY_EN
         StPar: begin
            if (abort || !more_passes) state_d = StIdle;
            else                       state_d = StShift;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Output and datapath next values; outputs default to their idle values.
   always_comb begin
      pat_d   = pat_q;
      pass_d  = pass_q;
      idx_d   = idx_q;
      x_d     = 1'b0;
      t_d     = 1'b0;
      busy_d  = 1'b0;
      ready_d = 1'b1;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               pat_d   = pattern;
               pass_d  = repeat_n;
               idx_d   = IdxTop;
               x_d     = pattern[WIDTH-1];
               t_d     = 1'b1;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         end
         StShift: begin
            if (abort) begin
               pass_d = '0;
               idx_d  = '0;
            end else if (!last_bit) begin
               idx_d   = idx_m1;
               x_d     = pat_q[idx_m1];
               t_d     = 1'b1;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end else begin
`ifdef PARITY_EN
               x_d     = ^pat_q;
               t_d     = 1'b1;
               busy_d  = 1'b1;
               ready_d = 1'b0;
`else
               if (more_passes) begin
                  pass_d  = pass_q - CNT_W'(1);
                  idx_d   = IdxTop;
                  x_d     = pat_q[WIDTH-1];
                  t_d     = 1'b1;
                  busy_d  = 1'b1;
                  ready_d = 1'b0;
               end else begin
                  done_d = 1'b1;
               end
`endif
            end
         end
`ifdef PARITY_EN
         StPar: begin
            if (abort) begin
               pass_d = '0;
               idx_d  = '0;
            end else if (more_passes) begin
               pass_d  = pass_q - CNT_W'(1);
               idx_d   = IdxTop;
               x_d     = pat_q[WIDTH-1];
               t_d     = 1'b1;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
`endif
         default: begin
            pass_d = '0;
            idx_d  = '0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q   <= '0;
         pass_q  <= '0;
         idx_q   <= '0;
         x_q     <= 1'b0;
         t_q     <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         pass_q  <= pass_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         t_q     <= t_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign x     = x_q;
   assign t     = t_q;
   assign busy  = busy_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the expected serial bit stream.
module tb_serial_pattern_tx;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] pattern = '0;
   logic [CNT_W-1:0] repeat_n = '0;
   logic             ready, busy, x, t, done;

   serial_pattern_tx #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .abort   (abort),
      .pattern (pattern),
      .repeat_n(repeat_n),
      .ready   (ready),
      .busy    (busy),
      .x       (x),
      .t       (t),
      .done    (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: queue of bits still to appear on x, plus expected output values.
   bit   m_q[$];
   logic m_busy, m_ready, m_x, m_t, m_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ".t"},     32'(t),     32'(m_t));
      check_eq({tag, ".x"},     32'(x),     32'(m_x));
      check_eq({tag, ".busy"},  32'(busy),  32'(m_busy));
      check_eq({tag, ".ready"}, 32'(ready), 32'(m_ready));
      check_eq({tag, ".done"},  32'(done),  32'(m_done));
   endtask

   task automatic model_idle(input logic d);
      m_busy  = 1'b0;
      m_ready = 1'b1;
      m_x     = 1'b0;
      m_t     = 1'b0;
      m_done  = d;
   endtask

   // Expected outputs after the next rising edge, given the inputs applied for it.
   task automatic model_edge(input logic s, input logic a, input logic [WIDTH-1:0] p,
                             input logic [CNT_W-1:0] r);
      if (m_busy) begin
         if (a) begin
            m_q.delete();
            model_idle(1'b0);
         end else if (m_q.size() > 0) begin
            m_x    = m_q.pop_front();
            m_t    = 1'b1;
            m_done = 1'b0;
         end else begin
            model_idle(1'b1);
         end
      end else if (s && !a) begin
         for (int pass = 0; pass <= int'(r); pass++) begin
            for (int i = WIDTH - 1; i >= 0; i--) m_q.push_back(p[i]);
`ifdef PARITY_EN
            m_q.push_back(^p);
`endif
         end
         m_x     = m_q.pop_front();
         m_t     = 1'b1;
         m_busy  = 1'b1;
         m_ready = 1'b0;
         m_done  = 1'b0;
      end else begin
         model_idle(1'b0);
      end
   endtask

   task automatic step(input string tag, input logic s, input logic a,
                       input logic [WIDTH-1:0] p, input logic [CNT_W-1:0] r);
      @(negedge clk);
      check_outputs(tag);
      start    = s;
      abort    = a;
      pattern  = p;
      repeat_n = r;
      model_edge(s, a, p, r);
   endtask

   task automatic idle_steps(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, WIDTH'($urandom), CNT_W'($urandom));
   endtask

   initial begin
      model_idle(1'b0);
      repeat (3) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;

      // Single pass of A5.
      step("a5", 1'b1, 1'b0, 8'hA5, 4'd0);
      idle_steps("a5", 11);

      // C3 sent three times.
      step("c3", 1'b1, 1'b0, 8'hC3, 4'd2);
      idle_steps("c3", 27);

      // Start during busy ignored, then abort at bit 3.
      step("abt", 1'b1, 1'b0, 8'h5A, 4'd1);
      for (int i = 0; i < 4; i++) step("abt", 1'b1, 1'b0, 8'hFF, 4'd3);
      step("abt", 1'b0, 1'b1, 8'h00, 4'd0);
      idle_steps("abt", 3);
      // Start and abort together in idle.
      step("sa", 1'b1, 1'b1, 8'hFF, 4'd1);
      idle_steps("sa", 3);

      // Start held high: back-to-back transfers.
      for (int i = 0; i < 40; i++) step("b2b", 1'b1, 1'b0, 8'h96, 4'd1);
      idle_steps("b2b", 20);

      // Maximum repeat count: exactly 2^CNT_W passes.
      step("max", 1'b1, 1'b0, WIDTH'($urandom), 4'hF);
      idle_steps("max", 170);

`ifdef PARITY_EN
      step("par", 1'b1, 1'b0, 8'h07, 4'd1);
      idle_steps("par", 22);
`endif

      // Asynchronous reset mid-transfer.
      step("rst", 1'b1, 1'b0, 8'h3C, 4'd1);
      idle_steps("rst", 4);
      rst_n = 1'b0;
      #1;
      m_q.delete();
      model_idle(1'b0);
      check_outputs("rst_async");
      idle_steps("rst_hold", 2);
      rst_n = 1'b1;
      idle_steps("rst_after", 3);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic             s, a;
         logic [CNT_W-1:0] r;
         s = ($urandom_range(0, 3) == 0);
         a = ($urandom_range(0, 40) == 0);
         r = ($urandom_range(0, 15) == 0) ? 4'hF : CNT_W'($urandom_range(0, 2));
         step("rnd", s, a, WIDTH'($urandom), r);
      end
      @(negedge clk);
      check_outputs("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
